// File: rtl/memory_access_pkg.sv
// Shared definitions for the ME pipeline stage: widths, port FSM state codes,
// word-alignment mask and the completion record handed to the ME register.
package memory_access_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    // Clearing the low two bits yields the word address presented to memory.
    localparam logic [XLEN-1:0] DMEM_WORD_ALIGN = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } dmemState_t;

    // Result of a completed ME-stage op; err forces the register write off.
    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            err;
    } meResult_t;

    function automatic logic isWordAligned(input logic [XLEN-1:0] addr);
        return (addr & ~DMEM_WORD_ALIGN) == '0;
    endfunction

endpackage

// File: rtl/memory_access_dmem_port_fsm.sv
// Data-memory port controller for the ME stage.
// Issues one req/ack transaction per load/store, holds address/data stable
// while DMemReq is high, times out after TIMEOUT request cycles, buffers load
// data while the pipeline is held and drains a flushed access to completion.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   flush, AnyStall       pipeline control
//   Result_EX, WrDat_EX   address / store data from the EX register
//   MemToReg_EX/MemWrite_EX  op is a load / store
//   DMem*                 data-memory req/ack port
//   Stall_ME              access pending (combinational)
//   MemErr                sticky misalignment / timeout flag
//   opDone, opResult      op at EX completes this cycle and its result
module memory_access_dmem_port_fsm
    import memory_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            AnyStall,
    input  logic [XLEN-1:0] Result_EX,
    input  logic [XLEN-1:0] WrDat_EX,
    input  logic            MemToReg_EX,
    input  logic            MemWrite_EX,
    output logic            DMemReq,
    output logic            DMemWe,
    output logic [XLEN-1:0] DMemAddr,
    output logic [XLEN-1:0] DMemWrDat,
    input  logic            DMemAck,
    input  logic [XLEN-1:0] DMemRdDat,
    output logic            Stall_ME,
    output logic            MemErr,
    output logic            opDone,
    output meResult_t       opResult
);

    dmemState_t      state, stateNext;
    logic [TO_W-1:0] cnt, cntNext;
    logic            reqNext, weNext, errNext;
    logic [XLEN-1:0] addrNext, wrDatNext;
    logic [XLEN-1:0] rbuf, rbufNext;
    logic            rbufErr, rbufErrNext;

    logic            acc, aligned, timeoutHit, busyDone;
    logic [XLEN-1:0] ackData;

    assign acc        = MemToReg_EX | MemWrite_EX;
    assign aligned    = isWordAligned(Result_EX);
    assign timeoutHit = (cnt == TO_W'(TIMEOUT - 1));
    assign busyDone   = DMemAck | timeoutHit;
    // A store completes with its address as the ME result.
    assign ackData    = DMemWe ? Result_EX : DMemRdDat;

    // State and port registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            DMemReq   <= 1'b0;
            DMemWe    <= 1'b0;
            DMemAddr  <= '0;
            DMemWrDat <= '0;
            MemErr    <= 1'b0;
            rbuf      <= '0;
            rbufErr   <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            DMemReq   <= reqNext;
            DMemWe    <= weNext;
            DMemAddr  <= addrNext;
            DMemWrDat <= wrDatNext;
            MemErr    <= errNext;
            rbuf      <= rbufNext;
            rbufErr   <= rbufErrNext;
        end
    end

    // Next-state, completion and stall decode
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        reqNext     = DMemReq;
        weNext      = DMemWe;
        addrNext    = DMemAddr;
        wrDatNext   = DMemWrDat;
        errNext     = MemErr;
        rbufNext    = rbuf;
        rbufErrNext = rbufErr;
        opDone      = 1'b0;
        opResult    = '0;
        Stall_ME    = 1'b0;

        unique case (state)
            IDLE: begin
                if (acc && !aligned) begin
                    opDone   = 1'b1;
                    opResult = '{data: '0, err: 1'b1};
                    if (!flush) errNext = 1'b1;
                end else if (acc) begin
                    Stall_ME = 1'b1;
                    if (!flush) begin
                        stateNext = BUSY;
                        cntNext   = '0;
                        reqNext   = 1'b1;
                        weNext    = MemWrite_EX;
                        addrNext  = Result_EX & DMEM_WORD_ALIGN;
                        wrDatNext = WrDat_EX;
                    end
                end else begin
                    opDone   = 1'b1;
                    opResult = '{data: Result_EX, err: 1'b0};
                end
            end

            BUSY: begin
                cntNext = cnt + TO_W'(1);
                // Stall drops on the completing cycle so AnyStall then reflects only other stages.
                Stall_ME = !busyDone;
                if (busyDone) begin
                    opDone   = 1'b1;
                    opResult = DMemAck ? '{data: ackData, err: 1'b0}
                                       : '{data: '0, err: 1'b1};
                    reqNext  = 1'b0;
                    if (!DMemAck) errNext = 1'b1;
                    if (flush || !AnyStall) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext   = HOLD;
                        rbufNext    = opResult.data;
                        rbufErrNext = opResult.err;
                    end
                end else if (flush) begin
                    stateNext = DRAIN;
                end
            end

            HOLD: begin
                if (flush) begin
                    stateNext = IDLE;
                end else if (!AnyStall) begin
                    opDone    = 1'b1;
                    opResult  = '{data: rbuf, err: rbufErr};
                    stateNext = IDLE;
                end
            end

            DRAIN: begin
                // Flushed access: keep the bus transaction alive, discard its data.
                Stall_ME = 1'b1;
                cntNext  = cnt + TO_W'(1);
                if (busyDone) begin
                    reqNext   = 1'b0;
                    stateNext = IDLE;
                    if (!DMemAck) errNext = 1'b1;
                end
            end

            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// ME pipeline stage: runs loads/stores from the EX register on the req/ack
// data-memory port and produces the ME register for writeback and bypass.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   flush, AnyStall              pipeline clear / global hold
//   Result_EX, WrDat_EX, WriteReg_EX, RegWrite_EX, MemToReg_EX, MemWrite_EX
//                                EX pipeline register
//   DMemReq/We/Addr/WrDat/Ack/RdDat   data-memory port
//   ResultRdDat_ME, WriteReg_ME, RegWrite_ME   ME pipeline register
//   Stall_ME                     access pending
//   MemErr                       sticky misalignment / timeout flag
module memory_access
    import memory_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             AnyStall,
    input  logic [XLEN-1:0]  Result_EX,
    input  logic [XLEN-1:0]  WrDat_EX,
    input  logic [REG_W-1:0] WriteReg_EX,
    input  logic             RegWrite_EX,
    input  logic             MemToReg_EX,
    input  logic             MemWrite_EX,
    output logic             DMemReq,
    output logic             DMemWe,
    output logic [XLEN-1:0]  DMemAddr,
    output logic [XLEN-1:0]  DMemWrDat,
    input  logic             DMemAck,
    input  logic [XLEN-1:0]  DMemRdDat,
    output logic [XLEN-1:0]  ResultRdDat_ME,
    output logic [REG_W-1:0] WriteReg_ME,
    output logic             RegWrite_ME,
    output logic             Stall_ME,
    output logic             MemErr
);

    logic      opDone;
    meResult_t opResult;

    memory_access_dmem_port_fsm #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_dmemPortFsm (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .AnyStall    (AnyStall),
        .Result_EX   (Result_EX),
        .WrDat_EX    (WrDat_EX),
        .MemToReg_EX (MemToReg_EX),
        .MemWrite_EX (MemWrite_EX),
        .DMemReq     (DMemReq),
        .DMemWe      (DMemWe),
        .DMemAddr    (DMemAddr),
        .DMemWrDat   (DMemWrDat),
        .DMemAck     (DMemAck),
        .DMemRdDat   (DMemRdDat),
        .Stall_ME    (Stall_ME),
        .MemErr      (MemErr),
        .opDone      (opDone),
        .opResult    (opResult)
    );

    // ME pipeline register: flush beats load, stall holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ResultRdDat_ME <= '0;
            WriteReg_ME    <= '0;
            RegWrite_ME    <= 1'b0;
        end else if (flush) begin
            ResultRdDat_ME <= '0;
            WriteReg_ME    <= '0;
            RegWrite_ME    <= 1'b0;
        end else if (!AnyStall && opDone) begin
            ResultRdDat_ME <= opResult.data;
            WriteReg_ME    <= WriteReg_EX;
            RegWrite_ME    <= RegWrite_EX & ~opResult.err;
        end
    end

endmodule
